// File: rtl/ps2_key_matrix_pkg.sv
// Shared constants, prefix-state encoding and scancode lookup for the
// PS/2 key-matrix decoder.
package ps2_key_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_BRK     = 2'd1,
    PS_EXT     = 2'd2,
    PS_EXT_BRK = 2'd3
  } prefix_state_e;

  // Returns {hit, index}; index is the CHIP-8 hex key (0-F) or 16-19 for arrows.
  function automatic logic [5:0] map_scancode(input logic ext, input logic [7:0] code);
    logic [5:0] res;
    res = 6'd0;
    if (ext) begin
      case (code)
        8'h75:   res = {1'b1, 5'd16};
        8'h72:   res = {1'b1, 5'd17};
        8'h6B:   res = {1'b1, 5'd18};
        8'h74:   res = {1'b1, 5'd19};
        default: res = 6'd0;
      endcase
    end else begin
      case (code)
        8'h16:   res = {1'b1, 5'd1};
        8'h1E:   res = {1'b1, 5'd2};
        8'h26:   res = {1'b1, 5'd3};
        8'h25:   res = {1'b1, 5'd12};
        8'h15:   res = {1'b1, 5'd4};
        8'h1D:   res = {1'b1, 5'd5};
        8'h24:   res = {1'b1, 5'd6};
        8'h2D:   res = {1'b1, 5'd13};
        8'h1C:   res = {1'b1, 5'd7};
        8'h1B:   res = {1'b1, 5'd8};
        8'h23:   res = {1'b1, 5'd9};
        8'h2B:   res = {1'b1, 5'd14};
        8'h1A:   res = {1'b1, 5'd10};
        8'h22:   res = {1'b1, 5'd0};
        8'h21:   res = {1'b1, 5'd11};
        8'h2A:   res = {1'b1, 5'd15};
        default: res = 6'd0;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_key_matrix_if.sv
// Byte-stream input, control strobes and key/event outputs of the decoder.
interface ps2_key_matrix_if #(
  parameter int NUM_KEYS = 16,
  parameter int KEY_W    = $clog2(NUM_KEYS)
);
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                clear;
  logic                evt_pop;
  logic [NUM_KEYS-1:0] key_matrix;
  logic                any_down;
  logic                evt_valid;
  logic [KEY_W-1:0]    evt_key;
  logic                evt_down;
  logic                evt_overflow;

  modport master (
    output byte_valid, byte_data, clear, evt_pop,
    input  key_matrix, any_down, evt_valid, evt_key, evt_down, evt_overflow
  );

  modport slave (
    input  byte_valid, byte_data, clear, evt_pop,
    output key_matrix, any_down, evt_valid, evt_key, evt_down, evt_overflow
  );
endinterface

// File: rtl/ps2_key_matrix_fifo.sv
// Show-ahead event queue; a push against a full queue is dropped unless a
// pop frees a slot in the same cycle.
module key_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign valid     = (count_r != {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop & valid;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head      = valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 scancode decoder: prefix tracking, held-key matrix with repeat
// suppression, and a press/release event queue for wait-for-key.
module ps2_key_matrix
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_W      = $clog2(NUM_KEYS)
) (
  input logic             clk,
  input logic             rst,
  ps2_key_matrix_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = PS_IDLE;
  localparam logic [1:0] ST_BRK     = PS_BRK;
  localparam logic [1:0] ST_EXT     = PS_EXT;
  localparam logic [1:0] ST_EXT_BRK = PS_EXT_BRK;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic                decode_s;
  logic                brk_s;
  logic                ext_s;
  logic [5:0]          map_s;
  logic [KEY_W-1:0]    key_idx_s;
  logic                hit_s;
  logic                held_s;
  logic                push_s;
  logic [NUM_KEYS-1:0] matrix_r;
  logic [NUM_KEYS-1:0] matrix_nxt_s;
  logic                any_down_r;
  logic                overflow_r;
  logic                fifo_valid_s;
  logic                fifo_full_s;
  logic                pop_eff_s;
  logic [KEY_W:0]      fifo_head_s;

  // Prefix FSM: repeated F0/E0 only accumulate; any other byte is decoded.
  always_comb begin
    state_nxt_s = state_r;
    decode_s    = 1'b0;
    brk_s       = 1'b0;
    ext_s       = 1'b0;
    if (bus.byte_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.byte_data == SC_BREAK)    state_nxt_s = ST_BRK;
          else if (bus.byte_data == SC_EXT) state_nxt_s = ST_EXT;
          else begin decode_s = 1'b1; state_nxt_s = ST_IDLE; end
        end
        ST_BRK: begin
          if (bus.byte_data == SC_BREAK)    state_nxt_s = ST_BRK;
          else if (bus.byte_data == SC_EXT) state_nxt_s = ST_EXT_BRK;
          else begin decode_s = 1'b1; brk_s = 1'b1; state_nxt_s = ST_IDLE; end
        end
        ST_EXT: begin
          if (bus.byte_data == SC_EXT)        state_nxt_s = ST_EXT;
          else if (bus.byte_data == SC_BREAK) state_nxt_s = ST_EXT_BRK;
          else begin decode_s = 1'b1; ext_s = 1'b1; state_nxt_s = ST_IDLE; end
        end
        ST_EXT_BRK: begin
          if ((bus.byte_data == SC_BREAK) || (bus.byte_data == SC_EXT)) begin
            state_nxt_s = ST_EXT_BRK;
          end else begin
            decode_s = 1'b1; brk_s = 1'b1; ext_s = 1'b1; state_nxt_s = ST_IDLE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Arrow indices beyond the matrix width are treated as unmapped.
  assign map_s     = map_scancode(ext_s, bus.byte_data);
  assign key_idx_s = map_s[KEY_W-1:0];
  assign hit_s     = decode_s & map_s[5] & (32'(map_s[4:0]) < NUM_KEYS);
  assign held_s    = matrix_r[key_idx_s];
  assign push_s    = hit_s & (brk_s ? held_s : ~held_s);
  assign pop_eff_s = bus.evt_pop & fifo_valid_s;

  // Only a real state change (press of an up key, release of a down key) edits the matrix.
  always_comb begin
    matrix_nxt_s = matrix_r;
    if (push_s) begin
      matrix_nxt_s[key_idx_s] = ~brk_s;
    end else begin
      matrix_nxt_s = matrix_r;
    end
  end

  // Prefix state, matrix, any-down and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_r    <= ST_IDLE;
      matrix_r   <= {NUM_KEYS{1'b0}};
      any_down_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      matrix_r   <= matrix_nxt_s;
      any_down_r <= |matrix_r;
      overflow_r <= overflow_r | (push_s & fifo_full_s & ~pop_eff_s);
    end
  end

  key_event_fifo #(
    .WIDTH (KEY_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.clear),
    .push      (push_s),
    .push_data ({~brk_s, key_idx_s}),
    .pop       (bus.evt_pop),
    .valid     (fifo_valid_s),
    .full      (fifo_full_s),
    .head      (fifo_head_s)
  );

  assign bus.key_matrix   = matrix_r;
  assign bus.any_down     = any_down_r;
  assign bus.evt_valid    = fifo_valid_s;
  assign bus.evt_key      = fifo_head_s[KEY_W-1:0];
  assign bus.evt_down     = fifo_head_s[KEY_W];
  assign bus.evt_overflow = overflow_r;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Bench for ps2_key_matrix: 16- and 20-key instances share one stimulus
// stream and are compared every cycle against a flag/array reference model.
module tb_ps2_key_matrix;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       clear;
  logic       evt_pop;

  always #5 clk = ~clk;

  ps2_key_matrix_if #(.NUM_KEYS(16)) if16 ();
  ps2_key_matrix_if #(.NUM_KEYS(20)) if20 ();

  assign if16.byte_valid = byte_valid;
  assign if16.byte_data  = byte_data;
  assign if16.clear      = clear;
  assign if16.evt_pop    = evt_pop;
  assign if20.byte_valid = byte_valid;
  assign if20.byte_data  = byte_data;
  assign if20.clear      = clear;
  assign if20.evt_pop    = evt_pop;

  ps2_key_matrix #(.NUM_KEYS(16), .FIFO_DEPTH(4)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  ps2_key_matrix #(.NUM_KEYS(20), .FIFO_DEPTH(4)) dut20 (.clk(clk), .rst(rst), .bus(if20.slave));

  int checks = 0;
  int errors = 0;

  // Key k is produced by base_codes[k]; arrows 16..19 by E0 + ext_codes[k-16].
  logic [7:0] base_codes [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                                  8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
  logic [7:0] ext_codes  [4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] junk_codes [6]  = '{8'hAA, 8'hFA, 8'hE1, 8'h12, 8'h00, 8'h76};

  // Reference model, index 0 = 16 keys, 1 = 20 keys.
  bit         m_brk [2];
  bit         m_ext [2];
  logic [19:0] m_mat [2];
  logic       m_any [2];
  logic       m_ovf [2];
  logic [5:0] m_q   [2][4];
  int         m_qn  [2];

  function automatic int lookup(bit ext, logic [7:0] code, int nk);
    if (!ext) begin
      for (int k = 0; k < 16; k++) if (base_codes[k] == code) return k;
    end else if (nk == 20) begin
      for (int j = 0; j < 4; j++) if (ext_codes[j] == code) return 16 + j;
    end
    return -1;
  endfunction

  task automatic model_step(int m, int nk, bit r, bit bv, logic [7:0] bd, bit clr, bit pop);
    logic       nxt_any;
    int         k;
    bit         have;
    logic [5:0] ev;
    nxt_any = |m_mat[m];
    if (r || clr) begin
      m_brk[m] = 1'b0; m_ext[m] = 1'b0; m_mat[m] = 20'd0;
      m_any[m] = 1'b0; m_ovf[m] = 1'b0; m_qn[m] = 0;
      return;
    end
    if (pop && m_qn[m] > 0) begin
      for (int i = 0; i < 3; i++) m_q[m][i] = m_q[m][i+1];
      m_qn[m] = m_qn[m] - 1;
    end
    if (bv) begin
      if (bd == 8'hF0) m_brk[m] = 1'b1;
      else if (bd == 8'hE0) m_ext[m] = 1'b1;
      else begin
        k = lookup(m_ext[m], bd, nk);
        have = 1'b0;
        ev = 6'd0;
        if (k >= 0) begin
          if (!m_brk[m] && !m_mat[m][k]) begin
            m_mat[m][k] = 1'b1; have = 1'b1; ev = {1'b1, 5'(k)};
          end else if (m_brk[m] && m_mat[m][k]) begin
            m_mat[m][k] = 1'b0; have = 1'b1; ev = {1'b0, 5'(k)};
          end
        end
        if (have) begin
          if (m_qn[m] < 4) begin
            m_q[m][m_qn[m]] = ev;
            m_qn[m] = m_qn[m] + 1;
          end else begin
            m_ovf[m] = 1'b1;
          end
        end
        m_brk[m] = 1'b0;
        m_ext[m] = 1'b0;
      end
    end
    m_any[m] = nxt_any;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("m16_matrix", 32'(if16.key_matrix), 32'(m_mat[0][15:0]));
    chk("m16_any",    32'(if16.any_down),   32'(m_any[0]));
    chk("m16_valid",  32'(if16.evt_valid),  32'(m_qn[0] > 0));
    chk("m16_ovf",    32'(if16.evt_overflow), 32'(m_ovf[0]));
    if (m_qn[0] > 0) begin
      chk("m16_key",  32'(if16.evt_key),  32'(m_q[0][0][3:0]));
      chk("m16_down", 32'(if16.evt_down), 32'(m_q[0][0][5]));
    end
    chk("m20_matrix", 32'(if20.key_matrix), 32'(m_mat[1]));
    chk("m20_any",    32'(if20.any_down),   32'(m_any[1]));
    chk("m20_valid",  32'(if20.evt_valid),  32'(m_qn[1] > 0));
    chk("m20_ovf",    32'(if20.evt_overflow), 32'(m_ovf[1]));
    if (m_qn[1] > 0) begin
      chk("m20_key",  32'(if20.evt_key),  32'(m_q[1][0][4:0]));
      chk("m20_down", 32'(if20.evt_down), 32'(m_q[1][0][5]));
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cycle(bit bv, logic [7:0] bd, bit clr, bit pop, bit r);
    byte_valid = bv; byte_data = bd; clear = clr; evt_pop = pop; rst = r;
    @(posedge clk);
    model_step(0, 16, r, bv, bd, clr, pop);
    model_step(1, 20, r, bv, bd, clr, pop);
    @(negedge clk);
    byte_valid = 1'b0; clear = 1'b0; evt_pop = 1'b0; rst = 1'b0;
    check_models();
  endtask

  task automatic send(logic [7:0] bd);
    cycle(1'b1, bd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic        bv;
    logic [7:0]  bd;
    logic        pop;
    logic [19:0] mat;
    logic        vld;
    logic [4:0]  key;
    logic        dn;
  } vec_t;

  vec_t vt [19];

  function automatic vec_t mkv(logic bv, logic [7:0] bd, logic pop, logic [19:0] mat,
                               logic vld, logic [4:0] key, logic dn);
    vec_t v;
    v.bv = bv; v.bd = bd; v.pop = pop; v.mat = mat; v.vld = vld; v.key = key; v.dn = dn;
    return v;
  endfunction

  initial begin
    int sel;
    logic [7:0] b;
    bit bv, pp, cl;

    vt[0]  = mkv(1'b1, 8'h1D, 1'b0, 20'h00020, 1'b1, 5'd5,  1'b1);
    vt[1]  = mkv(1'b1, 8'hF0, 1'b0, 20'h00020, 1'b1, 5'd5,  1'b1);
    vt[2]  = mkv(1'b1, 8'h1D, 1'b0, 20'h00000, 1'b1, 5'd5,  1'b1);
    vt[3]  = mkv(1'b0, 8'h00, 1'b1, 20'h00000, 1'b1, 5'd5,  1'b0);
    vt[4]  = mkv(1'b0, 8'h00, 1'b1, 20'h00000, 1'b0, 5'd0,  1'b0);
    vt[5]  = mkv(1'b1, 8'h16, 1'b0, 20'h00002, 1'b1, 5'd1,  1'b1);
    vt[6]  = mkv(1'b1, 8'h16, 1'b0, 20'h00002, 1'b1, 5'd1,  1'b1);
    vt[7]  = mkv(1'b1, 8'h16, 1'b0, 20'h00002, 1'b1, 5'd1,  1'b1);
    vt[8]  = mkv(1'b1, 8'hF0, 1'b0, 20'h00002, 1'b1, 5'd1,  1'b1);
    vt[9]  = mkv(1'b1, 8'h16, 1'b0, 20'h00000, 1'b1, 5'd1,  1'b1);
    vt[10] = mkv(1'b0, 8'h00, 1'b1, 20'h00000, 1'b1, 5'd1,  1'b0);
    vt[11] = mkv(1'b0, 8'h00, 1'b1, 20'h00000, 1'b0, 5'd0,  1'b0);
    vt[12] = mkv(1'b1, 8'hE0, 1'b0, 20'h00000, 1'b0, 5'd0,  1'b0);
    vt[13] = mkv(1'b1, 8'h75, 1'b0, 20'h10000, 1'b1, 5'd16, 1'b1);
    vt[14] = mkv(1'b1, 8'hE0, 1'b0, 20'h10000, 1'b1, 5'd16, 1'b1);
    vt[15] = mkv(1'b1, 8'hF0, 1'b0, 20'h10000, 1'b1, 5'd16, 1'b1);
    vt[16] = mkv(1'b1, 8'h75, 1'b0, 20'h00000, 1'b1, 5'd16, 1'b1);
    vt[17] = mkv(1'b0, 8'h00, 1'b1, 20'h00000, 1'b1, 5'd16, 1'b0);
    vt[18] = mkv(1'b0, 8'h00, 1'b1, 20'h00000, 1'b0, 5'd0,  1'b0);

    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; clear = 1'b0; evt_pop = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();
    chk("rst_matrix", 32'(if20.key_matrix), 32'd0);
    chk("rst_any",    32'(if20.any_down), 32'd0);
    chk("rst_valid",  32'(if20.evt_valid), 32'd0);
    chk("rst_key",    32'(if20.evt_key), 32'd0);
    chk("rst_down",   32'(if20.evt_down), 32'd0);
    chk("rst_ovf",    32'(if20.evt_overflow), 32'd0);

    for (int i = 0; i < 19; i++) begin
      cycle(vt[i].bv, vt[i].bd, 1'b0, vt[i].pop, 1'b0);
      chk("tbl_matrix", 32'(if20.key_matrix), 32'(vt[i].mat));
      chk("tbl_valid",  32'(if20.evt_valid), 32'(vt[i].vld));
      chk("tbl_ovf",    32'(if20.evt_overflow), 32'd0);
      if (vt[i].vld) begin
        chk("tbl_key",  32'(if20.evt_key), 32'(vt[i].key));
        chk("tbl_down", 32'(if20.evt_down), 32'(vt[i].dn));
      end
    end

    // Arrow keys are invisible to the 16-key instance.
    do_reset();
    send(8'hE0); send(8'h75);
    chk("ext16_matrix", 32'(if16.key_matrix), 32'd0);
    chk("ext16_valid",  32'(if16.evt_valid), 32'd0);
    chk("ext20_matrix", 32'(if20.key_matrix), 32'h10000);

    // Fifth make with no pops overflows; its matrix bit still sets.
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h15); send(8'h1D);
    chk("ovf_flag", 32'(if20.evt_overflow), 32'd1);
    chk("ovf_bit5", 32'(if20.key_matrix[5]), 32'd1);
    chk("ovf_head", 32'(if20.evt_key), 32'd1);
    pop_one(); pop_one(); pop_one();
    chk("ovf_last", 32'(if20.evt_key), 32'd4);
    pop_one();
    chk("ovf_empty", 32'(if20.evt_valid), 32'd0);
    chk("ovf_sticky", 32'(if20.evt_overflow), 32'd1);

    // Fifth make alongside a pop lands as the last entry.
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h15);
    cycle(1'b1, 8'h1D, 1'b0, 1'b1, 1'b0);
    chk("sim_ovf",  32'(if20.evt_overflow), 32'd0);
    chk("sim_head", 32'(if20.evt_key), 32'd2);
    pop_one(); pop_one(); pop_one();
    chk("sim_last_key",  32'(if20.evt_key), 32'd5);
    chk("sim_last_down", 32'(if20.evt_down), 32'd1);

    // Clear wins over a concurrent F0 and leaves no break prefix behind.
    do_reset();
    send(8'h22); send(8'h2A);
    cycle(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
    chk("clr_matrix", 32'(if20.key_matrix), 32'd0);
    chk("clr_valid",  32'(if20.evt_valid), 32'd0);
    send(8'h22);
    chk("clr_valid2", 32'(if20.evt_valid), 32'd1);
    chk("clr_key",    32'(if20.evt_key), 32'd0);
    chk("clr_down",   32'(if20.evt_down), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 9)       b = base_codes[$urandom_range(0, 15)];
      else if (sel < 12) b = ext_codes[$urandom_range(0, 3)];
      else if (sel < 15) b = 8'hF0;
      else if (sel < 17) b = 8'hE0;
      else               b = junk_codes[$urandom_range(0, 5)];
      bv = ($urandom_range(0, 9) < 7);
      pp = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 99) == 0);
      cycle(bv, b, cl, pp, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_matrix.md
# ps2_key_matrix

Parametrised PS/2 scancode-to-key-matrix decoder for the CHIP-8 system. It consumes the byte stream from the PS/2 receiver and tracks make, break (F0) and extended (E0) prefixes. It maintains a NUM_KEYS-wide held-key matrix for the CPU's key-skip instructions, and queues press/release events in a small FIFO so the CPU's wait-for-key instruction never misses a short tap.

## Interface
- NUM_KEYS, default 16: matrix width, 16 or 20. Keys 16–19 are the E0-prefixed arrows up/down/left/right. They are ignored when NUM_KEYS=16.
- FIFO_DEPTH, default 4: event queue depth, a power of two, at least 2.
- KEY_W, default $clog2(NUM_KEYS): derived key-index width. Never overridden.
- clk  in  1  system clock. The only clock.
- rst  in  1  synchronous, active-high reset.
- byte_valid  in  1  single-cycle strobe marking a received scancode byte. It is already synchronous to clk; the synchronizer lives upstream.
- byte_data  in  8  scancode byte. Qualified by byte_valid.
- clear  in  1  synchronous flush of matrix, FIFO, prefix state and overflow.
- evt_pop  in  1  consume the head event. Ignored when evt_valid=0.
- key_matrix  out  NUM_KEYS  bit k=1 while key k is held.
- any_down  out  1  OR-reduction of key_matrix, registered.
- evt_valid  out  1  FIFO not empty.
- evt_key  out  KEY_W  key index of the head event (show-ahead).
- evt_down  out  1  head event type: 1 = press, 0 = release.
- evt_overflow  out  1  sticky flag: an event was dropped.

## Operation
- Prefix FSM states: IDLE, BRK, EXT, EXT_BRK. It advances only on byte_valid.
  - IDLE: F0→BRK; E0→EXT; any other byte is a make code, decoded, then →IDLE.
  - BRK: F0→BRK; E0→EXT_BRK; any other byte is a break code, decoded, then →IDLE.
  - EXT: E0→EXT; F0→EXT_BRK; any other byte is an extended make, decoded, then →IDLE.
  - EXT_BRK: F0 or E0→EXT_BRK; any other byte is an extended break, decoded, then →IDLE.
- Base map (non-extended), scancode→key:
  - 16→1, 1E→2, 26→3, 25→C
  - 15→4, 1D→5, 24→6, 2D→D
  - 1C→7, 1B→8, 23→9, 2B→E
  - 1A→A, 22→0, 21→B, 2A→F
- Extended map, active only when NUM_KEYS=20: E0 75→16, E0 72→17, E0 6B→18, E0 74→19.
- Unmapped codes are ignored: no matrix change, no event, FSM returns to IDLE. This covers AA, FA, E1, E0 12 and others.
- Make of key k:
  - If key k is up: set bit k and push {1,k}.
  - If key k is already down (typematic repeat): no event.
- Break of key k:
  - If key k is down: clear bit k and push {0,k}.
  - If key k is already up: no event.
- FIFO push and pop:
  - Entry format is {down, key}.
  - Push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Full with no pop: the new event is dropped and evt_overflow is set.
- evt_overflow is cleared only by rst or clear.
- clear has priority over byte_valid and evt_pop in the same cycle; the byte is discarded.
- rst and clear have identical effects.

## Timing
- Reset values: key_matrix=0, any_down=0, evt_valid=0, evt_key=0, evt_down=0, evt_overflow=0, FSM=IDLE.
- Latency from the final byte_valid of a sequence:
  - key_matrix updates one cycle later.
  - any_down updates two cycles later.
  - evt_valid and the head fields are valid one cycle later.
- Pop: head advances on the cycle after evt_pop. The next entry is visible immediately.
- Simultaneous push and pop:
  - Non-empty FIFO: occupancy unchanged.
  - Empty FIFO: the pop is ignored and the push lands.
- Back-to-back byte_valid on consecutive cycles is supported at full rate.

## Structure
- Package ps2_key_pkg holds:
  - prefix constants SC_BREAK=8'hF0 and SC_EXT=8'hE0;
  - the FSM state enum;
  - function map_scancode(ext, code) returning {hit, index[4:0]}.
- Sub-module key_event_fifo (parametrised WIDTH, DEPTH): show-ahead, with a full flag and a drop-on-full push port.
- Top level holds the FSM, matrix register, repeat/up suppression and overflow flag.

## Test plan
- 1D, F0 1D → matrix bit 5 set, then clear; events {1,5} then {0,5}; evt_overflow=0.
- 16, 16, 16, F0 16 → exactly two events, {1,1} and {0,1}; repeats are suppressed.
- NUM_KEYS=20, E0 75, E0 F0 75 → bit 16 set then cleared. With NUM_KEYS=16 the same stream gives no change and no events.
- FIFO_DEPTH=4, no pops, five distinct makes → first four events queued; fifth key's matrix bit set but no event; evt_overflow=1.
- Fifth make issued on the same cycle as evt_pop → no drop and no overflow; FIFO stays full with the fifth event last.
- Press keys 0 and F, then assert clear together with byte_valid(F0) → matrix=0, evt_valid=0, FSM IDLE. A following 22 yields the make event {1,0}.
